div_run_sequencer: RTL and testbench



---
 rtl/div_run_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_div_run_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_run_sequencer.sv
// ---------------------------------------------------------------------------
// div_run_sequencer
//
// Sequences one run of an external divider.
//   - Waits for a Go pulse from the debouncer.
//   - Raises Start.
//   - Counts the clocks spent in compute (Qc).
//   - Latches that count when Done appears.
//   - Holds Ack until the divider has dropped Done and is back in its
//     initial state (Qi).
//
// Optional feature: defining DIV_RUN_MINMAX_EN adds the min_count and
// max_count outputs. They track the smallest and largest latched counts
// since reset.
//
// Parameters
//   CNT_W    width of the compute-cycle counter and of cycle_count
//   START_TO clocks Start is held waiting for Qc/Done before giving up
//
// Ports
//   board_clk    in   clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   Go           in   single-cycle run request (honoured only in IDLE)
//   Qi, Qc, Done in   divider state: initial, computing, done
//   Start        out  high while waiting for the divider to begin
//   Ack          out  high while waiting for the divider to release Done
//   busy         out  high whenever not IDLE
//   cycle_count  out  compute-cycle count of the last completed run
//   count_valid  out  cycle_count holds a result of the current run
//   sat          out  counter reached all-ones during this run
//   err          out  the divider never responded to Start (sticky)
//   min_count    out  (DIV_RUN_MINMAX_EN) smallest latched count
//   max_count    out  (DIV_RUN_MINMAX_EN) largest latched count
// ---------------------------------------------------------------------------
module div_run_sequencer #(
  parameter int CNT_W    = 16,
  parameter int START_TO = 15
) (
  input  logic             board_clk,
  input  logic             Reset,
  input  logic             Go,
  input  logic             Qi,
  input  logic             Qc,
  input  logic             Done,
  output logic             Start,
  output logic             Ack,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count,
  output logic             count_valid,
  output logic             sat,
  output logic             err
`ifdef DIV_RUN_MINMAX_EN
  ,
  output logic [CNT_W-1:0] min_count,
  output logic [CNT_W-1:0] max_count
`endif
);

  // The timeout counter only has to reach START_TO-1.
  localparam int TO_W = (START_TO > 1) ? $clog2(START_TO) : 1;

  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(START_TO - 1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_ACK     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cc_q, cc_d;
  logic             vld_q, vld_d;
  logic             sat_q, sat_d;
  logic             err_q, err_d;
  logic             latch_d;

  // Saturating increment: the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    state_d = state_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    cc_d    = cc_q;
    vld_d   = vld_q;
    sat_d   = sat_q;
    err_d   = err_q;
    latch_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Go) begin
          state_d = ST_START;
          to_d    = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          err_d   = 1'b0;
          vld_d   = 1'b0;
        end
      end

      ST_START: begin
        if (Done) begin
          // The divider finished without any compute cycles.
          state_d = ST_ACK;
          cnt_d   = '0;
          cc_d    = '0;
          vld_d   = 1'b1;
          latch_d = 1'b1;
        end else if (Qc) begin
          // The first compute cycle is seen here, so counting starts at 1.
          state_d = ST_MEASURE;
          cnt_d   = CNT_ONE;
          sat_d   = (CNT_ONE == CNT_MAX);
        end else if (to_q == TO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          vld_d   = 1'b0;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end

      ST_MEASURE: begin
        // Done takes priority, so a Qc sampled together with Done is not counted.
        if (Done) begin
          state_d = ST_ACK;
          cc_d    = cnt_q;
          vld_d   = 1'b1;
          latch_d = 1'b1;
        end else if (Qc) begin
          cnt_d = sat_inc(cnt_q);
          if (sat_inc(cnt_q) == CNT_MAX) begin
            sat_d = 1'b1;
          end
        end
      end

      ST_ACK: begin
        if (!Done && Qi) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Reset also clears the result registers, so a run cut short by Reset
  // leaves no trace.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      to_q    <= '0;
      cnt_q   <= '0;
      cc_q    <= '0;
      vld_q   <= 1'b0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      cc_q    <= cc_d;
      vld_q   <= vld_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  // Start and Ack are decoded from the state register, so they drop at the
  // same moment as the state when Reset is asserted.
  assign Start       = (state_q == ST_START);
  assign Ack         = (state_q == ST_ACK);
  assign busy        = (state_q != ST_IDLE);
  assign cycle_count = cc_q;
  assign count_valid = vld_q;
  assign sat         = sat_q;
  assign err         = err_q;

`ifdef DIV_RUN_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;

  // Only runs that produce a result update the extremes; a timeout never
  // raises latch_d.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (latch_d) begin
      if (cc_d < min_q) begin
        min_d = cc_d;
      end
      if (cc_d > max_q) begin
        max_d = cc_d;
      end
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      min_q <= CNT_MAX;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_count = min_q;
  assign max_count = max_q;
`endif

endmodule

// File: tb/tb_div_run_sequencer.sv
module tb_div_run_sequencer;

  logic        board_clk;
  logic        Reset;
  logic        Go;
  logic        Qi;
  logic        Qc;
  logic        Done;

  logic        Start, Ack, busy, count_valid, sat, err;
  logic [15:0] cycle_count;
  logic        Start4, Ack4, busy4, count_valid4, sat4, err4;
  logic [3:0]  cycle_count4;
`ifdef DIV_RUN_MINMAX_EN
  logic [15:0] min_count, max_count;
  logic [3:0]  min_count4, max_count4;
`endif

  int n_chk = 0;
  int n_err = 0;

  div_run_sequencer #(.CNT_W(16), .START_TO(15)) dut (
    .board_clk   (board_clk),
    .Reset       (Reset),
    .Go          (Go),
    .Qi          (Qi),
    .Qc          (Qc),
    .Done        (Done),
    .Start       (Start),
    .Ack         (Ack),
    .busy        (busy),
    .cycle_count (cycle_count),
    .count_valid (count_valid),
    .sat         (sat),
    .err         (err)
`ifdef DIV_RUN_MINMAX_EN
    ,
    .min_count   (min_count),
    .max_count   (max_count)
`endif
  );

  div_run_sequencer #(.CNT_W(4), .START_TO(15)) dut4 (
    .board_clk   (board_clk),
    .Reset       (Reset),
    .Go          (Go),
    .Qi          (Qi),
    .Qc          (Qc),
    .Done        (Done),
    .Start       (Start4),
    .Ack         (Ack4),
    .busy        (busy4),
    .cycle_count (cycle_count4),
    .count_valid (count_valid4),
    .sat         (sat4),
    .err         (err4)
`ifdef DIV_RUN_MINMAX_EN
    ,
    .min_count   (min_count4),
    .max_count   (max_count4)
`endif
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge board_clk);
    #1;
  endtask

  // One complete run against a divider model: Qc one clock after Start is
  // seen, nqc counted compute clocks, then Done (optionally with Qc still high).
  task automatic do_run(input string tag, input int nqc, input bit go_mid, input bit both);
    int exp4;
    exp4 = (nqc > 15) ? 15 : nqc;
    chk({tag, ".start_idle"}, Start, 0);
    Go = 1'b1;
    tick();
    Go = 1'b0;
    chk({tag, ".start_rise"}, Start, 1);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".vld_clr"}, count_valid, 0);
    chk({tag, ".err_clr"}, err, 0);
    chk({tag, ".sat4_clr"}, sat4, 0);
    Qi = 1'b0;
    tick();
    Qc = 1'b1;
    for (int i = 0; i < nqc; i++) begin
      Go = go_mid && (i == 3);
      tick();
      if (i == 0) chk({tag, ".start_drop"}, Start, 0);
    end
    Go   = 1'b0;
    Qc   = both;
    Done = 1'b1;
    tick();
    Qc = 1'b0;
    chk({tag, ".ack"}, Ack, 1);
    chk({tag, ".vld"}, count_valid, 1);
    chk({tag, ".cc"}, cycle_count, nqc);
    chk({tag, ".sat"}, sat, 0);
    chk({tag, ".cc4"}, cycle_count4, exp4);
    chk({tag, ".sat4"}, sat4, (nqc >= 15) ? 1 : 0);
    tick();
    chk({tag, ".ack_done"}, Ack, 1);
    Done = 1'b0;
    tick();
    chk({tag, ".ack_noqi"}, Ack, 1);
    Qi = 1'b1;
    tick();
    chk({tag, ".ack_drop"}, Ack, 0);
    chk({tag, ".busy_drop"}, busy, 0);
    chk({tag, ".cc_hold"}, cycle_count, nqc);
    chk({tag, ".vld_hold"}, count_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b1;
    Go    = 1'b0;
    Qi    = 1'b1;
    Qc    = 1'b0;
    Done  = 1'b0;
    tick();
    tick();
    chk("rst.start", Start, 0);
    chk("rst.ack", Ack, 0);
    chk("rst.busy", busy, 0);
    chk("rst.cc", cycle_count, 0);
    chk("rst.vld", count_valid, 0);
    chk("rst.sat", sat, 0);
    chk("rst.err", err, 0);
`ifdef DIV_RUN_MINMAX_EN
    chk("rst.min", min_count, 16'hFFFF);
    chk("rst.max", max_count, 0);
`endif
    Reset = 1'b0;
    tick();

    do_run("basic", 29, 1'b0, 1'b0);
    do_run("run8", 8, 1'b0, 1'b0);
    do_run("run40", 40, 1'b0, 1'b0);
`ifdef DIV_RUN_MINMAX_EN
    chk("mm.min", min_count, 8);
    chk("mm.max", max_count, 40);
    chk("mm.min4", min_count4, 8);
    chk("mm.max4", max_count4, 15);
`endif

    // Timeout: the divider never answers Start.
    Go = 1'b1;
    tick();
    Go = 1'b0;
    chk("to.vld_clr", count_valid, 0);
    n = 0;
    for (int i = 0; i < 40 && Start; i++) begin
      n++;
      tick();
    end
    chk("to.start_len", n, 15);
    chk("to.err", err, 1);
    chk("to.vld", count_valid, 0);
    chk("to.busy", busy, 0);
    tick();
    tick();
    chk("to.err_sticky", err, 1);
    chk("to.err4", err4, 1);
`ifdef DIV_RUN_MINMAX_EN
    chk("to.min", min_count, 8);
    chk("to.max", max_count, 40);
`endif

    do_run("sat20", 20, 1'b0, 1'b0);
    chk("sat20.err_clr", err, 0);
    do_run("gomid", 9, 1'b1, 1'b0);
    do_run("both5", 5, 1'b0, 1'b1);

    // Reset in the middle of a measurement at count 10.
    Go = 1'b1;
    tick();
    Go = 1'b0;
    Qi = 1'b0;
    tick();
    Qc = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("mid.busy_pre", busy, 1);
    Reset = 1'b1;
    #1;
    chk("mid.start", Start, 0);
    chk("mid.ack", Ack, 0);
    chk("mid.busy", busy, 0);
    chk("mid.cc", cycle_count, 0);
    chk("mid.vld", count_valid, 0);
    chk("mid.sat", sat, 0);
    chk("mid.err", err, 0);
    chk("mid.sat4", sat4, 0);
`ifdef DIV_RUN_MINMAX_EN
    chk("mid.min", min_count, 16'hFFFF);
    chk("mid.max", max_count, 0);
`endif
    Qc = 1'b0;
    Qi = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    do_run("post_rst", 7, 1'b0, 1'b0);
`ifdef DIV_RUN_MINMAX_EN
    chk("post.min", min_count, 7);
    chk("post.max", max_count, 7);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
